// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller and its display driver.
// Floors are encoded 1..FLOORS inside an 8-bit one-hot call vector; bit 0 is never used.
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   localparam int FLOOR_W = 3;
   localparam int BTN_W   = 8;

   function automatic logic [BTN_W-1:0] floor_mask(input int floors);
      return ~(8'hFF << (floors + 1)) & 8'hFE;
   endfunction

   function automatic logic [BTN_W-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      return 8'hFF << ({1'b0, f} + 4'd1);
   endfunction

   function automatic logic [BTN_W-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      return ~(8'hFF << f) & 8'hFE;
   endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Button/status bundle between the car controller (slave) and the board I/O side (master).
interface elevator_scheduler_if;
   import elevator_pkg::*;

   logic [BTN_W-1:0]   floor_btn;
   logic [FLOOR_W-1:0] elev_f_o;
   logic               dir_up;
   logic               moving;
   logic               door_open;
   logic [BTN_W-1:0]   pending_o;

   modport master (
      output floor_btn,
      input  elev_f_o, dir_up, moving, door_open, pending_o
   );

   modport slave (
      input  floor_btn,
      output elev_f_o, dir_up, moving, door_open, pending_o
   );
endinterface

// File: rtl/elev_timer.sv
// Loadable down-counter shared by floor travel and door dwell; holds at zero once expired.
module elev_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);
   logic [W-1:0] count_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= value;
      end else if (count_r != {W{1'b0}}) begin
         count_r <= count_r - W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});
endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car controller: latches calls, picks direction with a SCAN policy,
// times floor travel and door dwell, and drives the registered floor/status outputs.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int FLOORS      = 7,
   parameter int MOVE_CYCLES = 100_000_000,
   parameter int DOOR_CYCLES = 200_000_000
) (
   input logic                clk,
   input logic                rst,
   elevator_scheduler_if.slave bus
);
   localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TW      = $clog2(MAX_CYC);
   localparam logic [TW-1:0]    MOVE_LOAD  = TW'(MOVE_CYCLES - 1);
   localparam logic [TW-1:0]    DOOR_LOAD  = TW'(DOOR_CYCLES - 1);
   localparam logic [BTN_W-1:0] VALID_MASK = floor_mask(FLOORS);

   state_t             state_r, state_nx_s;
   logic [FLOOR_W-1:0] floor_r, floor_nx_s, step_floor_s;
   logic               dir_r, dir_nx_s, moving_r, door_r;
   logic [BTN_W-1:0]   pending_r, pending_nx_s, btn_s, pend_set_s, cur_bit_s, step_bit_s;
   logic               ahead_s, behind_s, step_ahead_s, step_behind_s, cur_press_s;
   logic               tmr_load_s, tmr_zero_s;
   logic [TW-1:0]      tmr_value_s;

   elev_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load_s),
      .value (tmr_value_s),
      .zero  (tmr_zero_s)
   );

   assign btn_s        = bus.floor_btn & VALID_MASK;
   assign cur_bit_s    = 8'd1 << floor_r;
   assign cur_press_s  = |(btn_s & cur_bit_s);
   assign step_floor_s = dir_r ? (floor_r + 3'd1) : (floor_r - 3'd1);
   assign step_bit_s   = 8'd1 << step_floor_s;

   // A press for the floor the car is parked at is served in place, never latched.
   always_comb begin
      pend_set_s = pending_r | btn_s;
      if (state_r != ST_MOVE) begin
         pend_set_s = pend_set_s & ~cur_bit_s;
      end else begin
         pend_set_s = pending_r | btn_s;
      end
   end

   assign ahead_s       = |(pend_set_s & (dir_r ? above_mask(floor_r) : below_mask(floor_r)));
   assign behind_s      = |(pend_set_s & (dir_r ? below_mask(floor_r) : above_mask(floor_r)));
   assign step_ahead_s  = |(pend_set_s & (dir_r ? above_mask(step_floor_s) : below_mask(step_floor_s)));
   assign step_behind_s = |(pend_set_s & (dir_r ? below_mask(step_floor_s) : above_mask(step_floor_s)));

   always_comb begin
      state_nx_s   = state_r;
      floor_nx_s   = floor_r;
      dir_nx_s     = dir_r;
      pending_nx_s = pend_set_s;
      tmr_load_s   = 1'b0;
      tmr_value_s  = MOVE_LOAD;
      case (state_r)
         ST_IDLE: begin
            if (cur_press_s) begin
               state_nx_s  = ST_DOOR;
               tmr_load_s  = 1'b1;
               tmr_value_s = DOOR_LOAD;
            end else if (ahead_s) begin
               state_nx_s = ST_MOVE;
               tmr_load_s = 1'b1;
            end else if (behind_s) begin
               state_nx_s = ST_MOVE;
               dir_nx_s   = ~dir_r;
               tmr_load_s = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_MOVE: begin
            // Arrival decisions look at the floor being stepped onto; its clear beats a same-edge press.
            if (tmr_zero_s) begin
               floor_nx_s = step_floor_s;
               if (|(pend_set_s & step_bit_s)) begin
                  pending_nx_s = pend_set_s & ~step_bit_s;
                  state_nx_s   = ST_DOOR;
                  tmr_load_s   = 1'b1;
                  tmr_value_s  = DOOR_LOAD;
               end else if (step_ahead_s) begin
                  tmr_load_s = 1'b1;
               end else if (step_behind_s) begin
                  dir_nx_s   = ~dir_r;
                  tmr_load_s = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_MOVE;
            end
         end
         ST_DOOR: begin
            if (cur_press_s) begin
               tmr_load_s  = 1'b1;
               tmr_value_s = DOOR_LOAD;
            end else if (tmr_zero_s) begin
               if (ahead_s) begin
                  state_nx_s = ST_MOVE;
                  tmr_load_s = 1'b1;
               end else if (behind_s) begin
                  state_nx_s = ST_MOVE;
                  dir_nx_s   = ~dir_r;
                  tmr_load_s = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_DOOR;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         floor_r   <= 3'd1;
         dir_r     <= 1'b1;
         pending_r <= 8'h00;
         moving_r  <= 1'b0;
         door_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         floor_r   <= floor_nx_s;
         dir_r     <= dir_nx_s;
         pending_r <= pending_nx_s;
         moving_r  <= (state_nx_s == ST_MOVE);
         door_r    <= (state_nx_s == ST_DOOR);
      end
   end

   assign bus.elev_f_o  = floor_r;
   assign bus.dir_up    = dir_r;
   assign bus.moving    = moving_r;
   assign bus.door_open = door_r;
   assign bus.pending_o = pending_r;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios plus random calls vs a behavioural model.
module tb_elevator_scheduler;
   localparam int FLOORS = 7;
   localparam int MOVE   = 4;
   localparam int DOOR   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   elevator_scheduler_if bus ();

   elevator_scheduler #(.FLOORS(FLOORS), .MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: car position, travel flags, cycles left in the current activity, call set.
   int       m_floor;
   bit       m_up, m_travel, m_door;
   int       m_left;
   bit [7:0] m_calls;

   function automatic bit any_call(input bit [7:0] calls, input int f, input bit up);
      for (int k = 1; k <= FLOORS; k++)
         if (calls[k] && (up ? (k > f) : (k < f))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_floor = 1; m_up = 1'b1; m_travel = 1'b0; m_door = 1'b0; m_left = 0; m_calls = 8'h00;
   endtask

   task automatic model_depart(input bit [7:0] calls);
      if (any_call(calls, m_floor, m_up)) begin
         m_travel = 1'b1; m_left = MOVE;
      end else if (any_call(calls, m_floor, !m_up)) begin
         m_up = !m_up; m_travel = 1'b1; m_left = MOVE;
      end
   endtask

   task automatic model_edge(input logic [7:0] btn);
      bit [7:0] nc;
      int nf;
      nc = m_calls;
      for (int k = 1; k <= FLOORS; k++) if (btn[k]) nc[k] = 1'b1;
      if (!m_travel) nc[m_floor] = 1'b0;
      if (m_travel) begin
         if (m_left > 1) m_left--;
         else begin
            nf = m_up ? m_floor + 1 : m_floor - 1;
            m_floor = nf;
            if (nc[nf]) begin
               nc[nf] = 1'b0; m_travel = 1'b0; m_door = 1'b1; m_left = DOOR;
            end else if (any_call(nc, nf, m_up)) m_left = MOVE;
            else if (any_call(nc, nf, !m_up)) begin m_up = !m_up; m_left = MOVE; end
            else m_travel = 1'b0;
         end
      end else if (m_door) begin
         if (btn[m_floor]) m_left = DOOR;
         else if (m_left > 1) m_left--;
         else begin m_door = 1'b0; model_depart(nc); end
      end else begin
         if (btn[m_floor]) begin m_door = 1'b1; m_left = DOOR; end
         else model_depart(nc);
      end
      m_calls = nc;
   endtask

   task automatic cycle(input logic [7:0] b);
      bus.floor_btn = b;
      @(posedge clk);
      #1;
      model_edge(b);
   endtask

   task automatic do_reset();
      bus.floor_btn = 8'h00;
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_door(input bit level, output bit ok);
      int n;
      n = 0;
      while ((bus.door_open != level) && (n < 80)) begin cycle(8'h00); n++; end
      ok = (bus.door_open == level);
   endtask

   task automatic test_reset();
      total += 5;
      if (bus.elev_f_o !== 3'd1) begin bad++; $display("FAIL reset_floor: got %0d want 1", bus.elev_f_o); end
      if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL reset_dir: got %0b want 1", bus.dir_up); end
      if (bus.moving !== 1'b0) begin bad++; $display("FAIL reset_moving: got %0b want 0", bus.moving); end
      if (bus.door_open !== 1'b0) begin bad++; $display("FAIL reset_door: got %0b want 0", bus.door_open); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL reset_pending: got %h want 00", bus.pending_o); end
   endtask

   task automatic test_single_call();
      cycle(8'h08);
      total += 3;
      if (bus.moving !== 1'b1) begin bad++; $display("FAIL single_moving: got %0b want 1", bus.moving); end
      if (bus.elev_f_o !== 3'd1) begin bad++; $display("FAIL single_start_floor: got %0d want 1", bus.elev_f_o); end
      if (bus.pending_o !== 8'h08) begin bad++; $display("FAIL single_pending: got %h want 08", bus.pending_o); end
      repeat (3) cycle(8'h00);
      total++;
      if (bus.elev_f_o !== 3'd1) begin bad++; $display("FAIL single_early_step: got %0d want 1", bus.elev_f_o); end
      cycle(8'h00);
      total++;
      if (bus.elev_f_o !== 3'd2) begin bad++; $display("FAIL single_floor2: got %0d want 2", bus.elev_f_o); end
      repeat (4) cycle(8'h00);
      total += 4;
      if (bus.elev_f_o !== 3'd3) begin bad++; $display("FAIL single_floor3: got %0d want 3", bus.elev_f_o); end
      if (bus.door_open !== 1'b1) begin bad++; $display("FAIL single_door_on: got %0b want 1", bus.door_open); end
      if (bus.moving !== 1'b0) begin bad++; $display("FAIL single_stop: got %0b want 0", bus.moving); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL single_cleared: got %h want 00", bus.pending_o); end
      repeat (2) cycle(8'h00);
      total++;
      if (bus.door_open !== 1'b1) begin bad++; $display("FAIL single_door_hold: got %0b want 1", bus.door_open); end
      cycle(8'h00);
      total += 2;
      if (bus.door_open !== 1'b0) begin bad++; $display("FAIL single_door_off: got %0b want 0", bus.door_open); end
      if (bus.moving !== 1'b0) begin bad++; $display("FAIL single_idle: got %0b want 0", bus.moving); end
   endtask

   task automatic test_scan();
      int n;
      bit ok;
      int want_f[3] = '{5, 6, 2};
      bit want_d[3] = '{1'b1, 1'b1, 1'b0};
      cycle(8'h40);
      n = 0;
      while ((bus.elev_f_o != 3'd4) && (n < 40)) begin cycle(8'h00); n++; end
      total++;
      if (bus.elev_f_o !== 3'd4 || bus.moving !== 1'b1) begin
         bad++; $display("FAIL scan_reach4: floor %0d moving %0b want 4/1", bus.elev_f_o, bus.moving);
      end
      cycle(8'h24);
      for (int i = 0; i < 3; i++) begin
         wait_door(1'b1, ok);
         total += 2;
         if (!ok || bus.elev_f_o !== 3'(want_f[i])) begin
            bad++; $display("FAIL scan_stop%0d: floor %0d door %0b want %0d/1", i, bus.elev_f_o, bus.door_open, want_f[i]);
         end
         if (bus.dir_up !== want_d[i]) begin
            bad++; $display("FAIL scan_dir%0d: got %0b want %0b", i, bus.dir_up, want_d[i]);
         end
         wait_door(1'b0, ok);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      cycle(8'h40);
      n = 0;
      while ((bus.elev_f_o != 3'd3) && (n < 40)) begin cycle(8'h00); n++; end
      total++;
      if (bus.elev_f_o !== 3'd3 || bus.moving !== 1'b1) begin
         bad++; $display("FAIL mid_setup: floor %0d moving %0b want 3/1", bus.elev_f_o, bus.moving);
      end
      #2 rst = 1'b1;
      #1;
      total += 4;
      if (bus.elev_f_o !== 3'd1) begin bad++; $display("FAIL mid_floor: got %0d want 1", bus.elev_f_o); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL mid_pending: got %h want 00", bus.pending_o); end
      if (bus.moving !== 1'b0) begin bad++; $display("FAIL mid_moving: got %0b want 0", bus.moving); end
      if (bus.door_open !== 1'b0) begin bad++; $display("FAIL mid_door: got %0b want 0", bus.door_open); end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_current_floor();
      do_reset();
      cycle(8'h02);
      total += 3;
      if (bus.door_open !== 1'b1) begin bad++; $display("FAIL cur_door: got %0b want 1", bus.door_open); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL cur_pending: got %h want 00", bus.pending_o); end
      if (bus.moving !== 1'b0) begin bad++; $display("FAIL cur_moving: got %0b want 0", bus.moving); end
      cycle(8'h00);
      cycle(8'h02);
      total += 2;
      if (bus.door_open !== 1'b1) begin bad++; $display("FAIL cur_press2: got %0b want 1", bus.door_open); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL cur_pending2: got %h want 00", bus.pending_o); end
      for (int i = 0; i < 2; i++) begin
         cycle(8'h00);
         total++;
         if (bus.door_open !== 1'b1) begin bad++; $display("FAIL cur_extend%0d: got %0b want 1", i, bus.door_open); end
      end
      cycle(8'h00);
      total++;
      if (bus.door_open !== 1'b0) begin bad++; $display("FAIL cur_close: got %0b want 0", bus.door_open); end
   endtask

   task automatic test_top_invalid();
      int nopen;
      bit prev;
      int of[2];
      bit od[2];
      do_reset();
      cycle(8'h80);
      cycle(8'h03);
      total++;
      if (bus.pending_o !== 8'h82) begin bad++; $display("FAIL top_pending: got %h want 82", bus.pending_o); end
      nopen = 0; prev = 1'b0; of = '{0, 0}; od = '{1'b0, 1'b0};
      for (int i = 0; i < 70; i++) begin
         cycle(8'h00);
         total++;
         if (bus.elev_f_o < 3'd1 || bus.elev_f_o > 3'(FLOORS)) begin
            bad++; $display("FAIL top_range: got %0d want 1..%0d", bus.elev_f_o, FLOORS);
         end
         if (bus.door_open && !prev) begin
            if (nopen < 2) begin of[nopen] = int'(bus.elev_f_o); od[nopen] = bus.dir_up; end
            nopen++;
         end
         prev = bus.door_open;
      end
      total += 3;
      if (nopen !== 2) begin bad++; $display("FAIL top_stops: got %0d want 2", nopen); end
      if (of[0] !== 7 || od[0] !== 1'b1) begin bad++; $display("FAIL top_first: floor %0d dir %0b want 7/1", of[0], od[0]); end
      if (of[1] !== 1 || od[1] !== 1'b0) begin bad++; $display("FAIL top_second: floor %0d dir %0b want 1/0", of[1], od[1]); end
      cycle(8'h01);
      total++;
      if ({bus.elev_f_o, bus.moving, bus.door_open, bus.pending_o} !== {3'd1, 1'b0, 1'b0, 8'h00}) begin
         bad++; $display("FAIL top_bit0: floor %0d mov %0b door %0b pend %h want 1/0/0/00",
                         bus.elev_f_o, bus.moving, bus.door_open, bus.pending_o);
      end
   endtask

   task automatic test_clear_wins();
      int high;
      cycle(8'h08);
      repeat (7) cycle(8'h00);
      cycle(8'h08);
      total += 3;
      if (bus.elev_f_o !== 3'd3) begin bad++; $display("FAIL clr_floor: got %0d want 3", bus.elev_f_o); end
      if (bus.door_open !== 1'b1) begin bad++; $display("FAIL clr_door: got %0b want 1", bus.door_open); end
      if (bus.pending_o !== 8'h00) begin bad++; $display("FAIL clr_pending: got %h want 00", bus.pending_o); end
      high = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(8'h00);
         if (bus.door_open) high++;
      end
      total++;
      if (high !== DOOR - 1) begin bad++; $display("FAIL clr_once: got %0d more open cycles want %0d", high, DOOR - 1); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         cycle(b);
         total++;
         if ({bus.elev_f_o, bus.dir_up, bus.moving, bus.door_open, bus.pending_o} !==
             {3'(m_floor), m_up, m_travel, m_door, m_calls}) begin
            bad++;
            $display("FAIL random_c%0d: got f%0d u%0b m%0b d%0b p%h want f%0d u%0b m%0b d%0b p%h", i,
                     bus.elev_f_o, bus.dir_up, bus.moving, bus.door_open, bus.pending_o,
                     m_floor, m_up, m_travel, m_door, m_calls);
         end
      end
   endtask

   initial begin
      bus.floor_btn = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_single_call();
      test_scan();
      test_reset_mid();
      test_current_floor();
      test_top_invalid();
      test_clear_wins();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
